// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle control FSM for a 32-bit MIPS-subset datapath.
// It sequences fetch/decode/execute/memory/writeback, stalls on mem_ready, and
// reports the instruction class, retire pulses and a retired-instruction count.
// The class output is named instr_class because "class" is a reserved word.
module mips_mc_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_ctl,
   output logic [1:0]       pc_source,
   output logic [1:0]       instr_class,
   output logic [3:0]       state,
   output logic             retire,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RTWB   = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_TRAP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   state_t           state_q, state_d;
   logic [1:0]       class_q, class_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             funct_ok;
   logic [3:0]       funct_alu;

   // zero only qualifies pc_write_cond inside the datapath; the FSM never branches on it.
   logic unused_zero;
   assign unused_zero = zero;

   // Map the R-type funct field to an ALU operation and flag unsupported codes.
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Next-state, class latch, sticky illegal flag and retire counter.
   always_comb begin
      state_d = state_q;
      class_d = class_q;
      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     begin state_d = S_EXEC;   class_d = 2'b00; end
               OP_LW, OP_SW: begin state_d = S_MEMADR; class_d = 2'b01; end
               OP_BEQ:       begin state_d = S_BRANCH; class_d = 2'b10; end
               OP_J:         begin state_d = S_JUMP;   class_d = 2'b11; end
               default:      begin state_d = S_TRAP;   class_d = 2'b00; end
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWR:  if (mem_ready) state_d = run ? S_FETCH : S_IDLE;
         S_MEMWB, S_RTWB, S_BRANCH, S_JUMP:
                   state_d = run ? S_FETCH : S_IDLE;
         S_EXEC:   state_d = funct_ok ? S_RTWB : S_TRAP;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_IDLE;
      endcase
      illegal_d = illegal_q | (state_d == S_TRAP);
      count_d   = count_q + CNT_W'(retire);
   end

   // State registers; reset forces IDLE so every control output drops at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         class_q   <= 2'b00;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
      end
   end

   // Moore control decode from the current state; only the FETCH/MEMWR completion
   // strobes look at mem_ready so the stall cycles keep enables stable.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_ctl       = 4'b0000;
      pc_source     = 2'b00;
      retire        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            alu_ctl   = ALU_ADD;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_ctl   = ALU_ADD;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctl   = ALU_ADD;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            retire    = mem_ready;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_ctl   = funct_alu;
         end
         S_RTWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_ctl       = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            retire        = 1'b1;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            retire    = 1'b1;
         end
         default: ;
      endcase
   end

   assign state       = state_q;
   assign instr_class = class_q;
   assign illegal     = illegal_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed testbench for mips_mc_ctrl (counter narrowed to 2 bits to exercise wrap).
module tb_mips_mc_ctrl;

   localparam int CNT_W = 2;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   // Control vector order: pw,pwc,iord,mr,mw,irw,m2r,rd,rw,asa | asb | alu | pcs
   localparam logic [17:0] C_FETCH  = {10'b1001010000, 2'b01, 4'b0010, 2'b00};
   localparam logic [17:0] C_FSTALL = {10'b0001000000, 2'b01, 4'b0010, 2'b00};
   localparam logic [17:0] C_DEC    = {10'b0000000000, 2'b11, 4'b0010, 2'b00};
   localparam logic [17:0] C_MADR   = {10'b0000000001, 2'b10, 4'b0010, 2'b00};
   localparam logic [17:0] C_MRD    = {10'b0011000000, 2'b00, 4'b0000, 2'b00};
   localparam logic [17:0] C_MWB    = {10'b0000001010, 2'b00, 4'b0000, 2'b00};
   localparam logic [17:0] C_MWR    = {10'b0010100000, 2'b00, 4'b0000, 2'b00};
   localparam logic [17:0] C_RTWB   = {10'b0000000110, 2'b00, 4'b0000, 2'b00};
   localparam logic [17:0] C_BR     = {10'b0100000001, 2'b00, 4'b0110, 2'b01};
   localparam logic [17:0] C_JMP    = {10'b1000000000, 2'b00, 4'b0000, 2'b10};

   localparam logic [5:0] R_FUNCT [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   localparam logic [3:0] R_ALU   [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
   localparam int         WRAP_EXP[5] = '{1, 2, 3, 0, 1};

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             run = 1'b0;
   logic [5:0]       opcode = '0;
   logic [5:0]       funct = '0;
   logic             zero = 1'b0;
   logic             mem_ready = 1'b1;
   logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]       alu_src_b, pc_source, instr_class;
   logic [3:0]       alu_ctl, state;
   logic             retire, illegal;
   logic [CNT_W-1:0] instr_count;
   logic [17:0]      ctl;
   logic [17:0]      exp_ctl;

   int n_cmp = 0;
   int n_err = 0;

   mips_mc_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
      .pc_source(pc_source), .instr_class(instr_class), .state(state),
      .retire(retire), .illegal(illegal), .instr_count(instr_count)
   );

   assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctl, pc_source};

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Assert reset mid-cycle, check the immediate effect, release just after an edge.
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_eq("rst_state", state, 0);
      chk_eq("rst_ctl", ctl, 0);
      chk_eq("rst_retire", retire, 0);
      chk_eq("rst_illegal", illegal, 0);
      chk_eq("rst_count", instr_count, 0);
      chk_eq("rst_class", instr_class, 0);
      run = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // R-type: all five functs back to back
      do_reset();
      run = 1'b1; opcode = OP_R;
      for (int i = 0; i < 5; i++) begin
         funct = R_FUNCT[i];
         tick();
         chk_eq("r_fetch_st", state, 1);
         chk_eq("r_fetch_ctl", ctl, C_FETCH);
         chk_eq("r_cnt", instr_count, i % 4);
         tick();
         chk_eq("r_dec_st", state, 2);
         chk_eq("r_dec_ctl", ctl, C_DEC);
         tick();
         exp_ctl = {10'b0000000001, 2'b00, R_ALU[i], 2'b00};
         chk_eq("r_exec_st", state, 7);
         chk_eq("r_exec_ctl", ctl, exp_ctl);
         chk_eq("r_class", instr_class, 0);
         chk_eq("r_exec_ret", retire, 0);
         if (i == 4) run = 1'b0;
         tick();
         chk_eq("r_wb_st", state, 8);
         chk_eq("r_wb_ctl", ctl, C_RTWB);
         chk_eq("r_wb_ret", retire, 1);
      end
      tick();
      chk_eq("r_idle_st", state, 0);
      chk_eq("r_idle_ctl", ctl, 0);
      chk_eq("r_final_cnt", instr_count, 1);

      // lw with two stall cycles in MEMRD (7 cycles total)
      do_reset();
      run = 1'b1; opcode = OP_LW;
      tick(); chk_eq("lw_c1", state, 1);
      tick(); chk_eq("lw_c2", state, 2);
      tick(); chk_eq("lw_c3", state, 3); chk_eq("lw_madr_ctl", ctl, C_MADR);
      mem_ready = 1'b0;
      tick(); chk_eq("lw_c4", state, 4); chk_eq("lw_rd_ctl4", ctl, C_MRD);
      tick(); chk_eq("lw_c5", state, 4); chk_eq("lw_rd_ctl5", ctl, C_MRD);
      tick(); chk_eq("lw_c6", state, 4);
      mem_ready = 1'b1; run = 1'b0; #1;
      chk_eq("lw_rd_ctl6", ctl, C_MRD);
      tick(); chk_eq("lw_c7", state, 5); chk_eq("lw_wb_ctl", ctl, C_MWB);
      chk_eq("lw_ret", retire, 1); chk_eq("lw_class", instr_class, 1);
      tick(); chk_eq("lw_idle", state, 0); chk_eq("lw_cnt", instr_count, 1);

      // sw, then a second sw with one MEMWR stall
      do_reset();
      run = 1'b1; opcode = OP_SW;
      tick(); chk_eq("sw_fetch_ctl", ctl, C_FETCH);
      tick(); chk_eq("sw_dec_ctl", ctl, C_DEC);
      tick(); chk_eq("sw_madr_ctl", ctl, C_MADR);
      tick(); chk_eq("sw_c4", state, 6); chk_eq("sw_wr_ctl", ctl, C_MWR);
      chk_eq("sw_ret", retire, 1); chk_eq("sw_class", instr_class, 1);
      tick(); chk_eq("sw_refetch", state, 1); chk_eq("sw_cnt1", instr_count, 1);
      tick(); tick();
      chk_eq("sw2_madr", state, 3);
      mem_ready = 1'b0;
      tick(); chk_eq("sw2_wr", state, 6); chk_eq("sw2_stall_ret", retire, 0);
      chk_eq("sw2_stall_ctl", ctl, C_MWR);
      tick(); chk_eq("sw2_hold", state, 6);
      mem_ready = 1'b1; run = 1'b0; #1;
      chk_eq("sw2_ret", retire, 1);
      tick(); chk_eq("sw2_idle", state, 0); chk_eq("sw2_cnt", instr_count, 2);

      // beq taken then not taken: identical control outputs
      do_reset();
      run = 1'b1; opcode = OP_BEQ; zero = 1'b1;
      tick(); tick();
      tick(); chk_eq("beq1_st", state, 9); chk_eq("beq1_ctl", ctl, C_BR);
      chk_eq("beq1_ret", retire, 1); chk_eq("beq_class", instr_class, 2);
      tick(); chk_eq("beq_cnt1", instr_count, 1);
      zero = 1'b0;
      tick(); tick();
      chk_eq("beq0_st", state, 9); chk_eq("beq0_ctl", ctl, C_BR);
      chk_eq("beq0_ret", retire, 1);
      run = 1'b0;
      tick(); chk_eq("beq_idle", state, 0); chk_eq("beq_cnt2", instr_count, 2);

      // j with a FETCH stall, then run dropped during the second JUMP
      do_reset();
      run = 1'b1; opcode = OP_J; mem_ready = 1'b0;
      tick(); chk_eq("j_fstall_ctl", ctl, C_FSTALL);
      tick(); chk_eq("j_fstall_st", state, 1); chk_eq("j_fstall_ctl2", ctl, C_FSTALL);
      mem_ready = 1'b1; #1;
      chk_eq("j_fetch_ctl", ctl, C_FETCH);
      tick(); chk_eq("j_dec", state, 2);
      tick(); chk_eq("j_st", state, 10); chk_eq("j_ctl", ctl, C_JMP);
      chk_eq("j_ret", retire, 1); chk_eq("j_class", instr_class, 3);
      tick(); chk_eq("j_cnt1", instr_count, 1);
      tick(); tick();
      chk_eq("j2_st", state, 10);
      run = 1'b0;
      tick(); chk_eq("j_idle", state, 0); chk_eq("j_idle_ctl", ctl, 0);
      chk_eq("j_idle_ret", retire, 0); chk_eq("j_cnt2", instr_count, 2);

      // Illegal opcode: TRAP after DECODE, sticky and deaf to run
      do_reset();
      run = 1'b1; opcode = 6'b111111;
      tick(); tick();
      tick(); chk_eq("iop_st", state, 11); chk_eq("iop_ill", illegal, 1);
      chk_eq("iop_ctl", ctl, 0); chk_eq("iop_ret", retire, 0);
      run = 1'b0;
      tick(); tick();
      chk_eq("iop_hold", state, 11); chk_eq("iop_ill2", illegal, 1);
      chk_eq("iop_cnt", instr_count, 0);

      // Illegal funct: TRAP after EXEC
      do_reset();
      run = 1'b1; opcode = OP_R; funct = 6'b000111;
      tick(); tick();
      tick(); chk_eq("ifn_exec", state, 7); chk_eq("ifn_ill0", illegal, 0);
      tick(); chk_eq("ifn_st", state, 11); chk_eq("ifn_ill", illegal, 1);
      chk_eq("ifn_cnt", instr_count, 0);

      // Reset pulsed mid-MEMRD after one retired jump
      do_reset();
      run = 1'b1; opcode = OP_J;
      tick(); tick(); tick();
      tick(); chk_eq("rm_cnt_pre", instr_count, 1);
      opcode = OP_LW;
      tick(); tick();
      mem_ready = 1'b0;
      tick(); chk_eq("rm_in_memrd", state, 4);
      do_reset();

      // Counter wrap: five jumps with a 2-bit counter
      run = 1'b1; opcode = OP_J;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         tick(); chk_eq("wrap_jump", state, 10);
         if (i == 4) run = 1'b0;
         tick(); chk_eq("wrap_cnt", instr_count, WRAP_EXP[i]);
      end
      chk_eq("wrap_idle", state, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
